// File: rtl/dac_sample_feeder.sv
`default_nettype none
// ============================================================================
// Module      : dac_sample_feeder
// Description : Sample-rate pacing stage ahead of the delta-sigma DAC. Buffers
//               producer samples in a small FIFO and presents one sample per
//               programmable period on a registered dac_in bus, with prefill,
//               underrun and enable/disable handling.
// Options     : DAC_UNDERRUN_CNT_EN adds a saturating 16-bit underrun counter.
// Revision    : 1.0 - initial release
// ============================================================================
module dac_sample_feeder #(
  parameter int RES        = 7,
  parameter int DEPTH_LOG2 = 4,
  parameter int DIV_W      = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [DIV_W-1:0]      rate_div,
  input  logic [RES:0]          s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic [RES:0]          dac_in,
  output logic                  sample_tick,
  output logic                  underrun,
  output logic [DEPTH_LOG2:0]   level
`ifdef DAC_UNDERRUN_CNT_EN
  ,
  output logic [15:0]           underrun_cnt
`endif
);

  localparam logic [DEPTH_LOG2:0] c_DEPTH = (DEPTH_LOG2+1)'(1 << DEPTH_LOG2);
  localparam logic [DEPTH_LOG2:0] c_HALF  = (DEPTH_LOG2+1)'(1 << (DEPTH_LOG2-1));
  localparam logic [RES:0]        c_MID   = (RES+1)'(1 << RES);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  state_t                  r_state;
  state_t                  w_state_next;
  logic [RES:0]            r_mem [0:(1<<DEPTH_LOG2)-1];
  logic [DEPTH_LOG2-1:0]   r_wr_ptr;
  logic [DEPTH_LOG2-1:0]   r_rd_ptr;
  logic [DEPTH_LOG2:0]     r_level;
  logic [DEPTH_LOG2:0]     w_level_next;
  logic                    r_full;
  logic [DIV_W-1:0]        r_div;
  logic                    r_tick;
  logic                    r_underrun;
  logic [RES:0]            r_dac;
  logic                    w_push;
  logic                    w_pop;
  logic                    w_empty_tick;
  logic                    w_div_hit;
  logic                    w_tick_next;

  // A tick is only honoured while running and enabled; disable wins over a tick.
  assign w_push       = s_valid && !r_full;
  assign w_pop        = (r_state == ST_RUN) && enable && r_tick && (r_level != '0);
  assign w_empty_tick = (r_state == ST_RUN) && enable && r_tick && (r_level == '0);
  assign w_div_hit    = (r_div >= rate_div);
  // No new tick is raised in the cycle an underrun drops us back to PRIME.
  assign w_tick_next  = (r_state == ST_RUN) && enable && w_div_hit && !w_empty_tick;

  assign s_ready     = !r_full;
  assign dac_in      = r_dac;
  assign sample_tick = r_tick;
  assign underrun    = r_underrun;
  assign level       = r_level;

  // Next FIFO occupancy from the push/pop pair.
  always_comb begin
    w_level_next = r_level;
    case ({w_push, w_pop})
      2'b10:   w_level_next = r_level + 1'b1;
      2'b01:   w_level_next = r_level - 1'b1;
      default: w_level_next = r_level;
    endcase
  end

  // Next-state decode for the IDLE / PRIME / RUN controller.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (enable) w_state_next = ST_PRIME;
      end
      ST_PRIME: begin
        if (!enable)                w_state_next = ST_IDLE;
        else if (r_level >= c_HALF) w_state_next = ST_RUN;
      end
      ST_RUN: begin
        if (!enable)          w_state_next = ST_IDLE;
        else if (w_empty_tick) w_state_next = ST_PRIME;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  // FIFO storage; contents need no reset since pointers are cleared.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= s_data;
  end

  // FIFO pointers, occupancy and registered full flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_full   <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_level <= w_level_next;
      r_full  <= (w_level_next == c_DEPTH);
    end
  end

  // Sample-period divider: counts 0..rate_div in RUN, held at zero otherwise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_div  <= '0;
      r_tick <= 1'b0;
    end else begin
      r_tick <= w_tick_next;
      if (r_state != ST_RUN) r_div <= '0;
      else if (w_div_hit)    r_div <= '0;
      else                   r_div <= r_div + 1'b1;
    end
  end

  // DAC output register and underrun pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_dac      <= c_MID;
      r_underrun <= 1'b0;
    end else begin
      r_underrun <= w_empty_tick;
      if (w_state_next == ST_IDLE) r_dac <= c_MID;
      else if (w_pop)              r_dac <= r_mem[r_rd_ptr];
    end
  end

`ifdef DAC_UNDERRUN_CNT_EN
  logic [15:0] r_underrun_cnt;
  assign underrun_cnt = r_underrun_cnt;

  // Saturating count of underrun events, cleared only by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                      r_underrun_cnt <= '0;
    else if (w_empty_tick && r_underrun_cnt != 16'hFFFF) r_underrun_cnt <= r_underrun_cnt + 1'b1;
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_dac_sample_feeder.sv
`default_nettype none
// ============================================================================
// Module      : tb_dac_sample_feeder
// Description : Randomized self-checking bench for dac_sample_feeder against a
//               queue-based behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dac_sample_feeder;

  localparam int RES        = 7;
  localparam int DEPTH_LOG2 = 4;
  localparam int DIV_W      = 16;
  localparam int DEPTH      = 1 << DEPTH_LOG2;
  localparam int HALF       = DEPTH / 2;
  localparam int MID        = 1 << RES;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              enable = 1'b0;
  logic [DIV_W-1:0]  rate_div = '0;
  logic [RES:0]      s_data = '0;
  logic              s_valid = 1'b0;
  logic              s_ready;
  logic [RES:0]      dac_in;
  logic              sample_tick;
  logic              underrun;
  logic [DEPTH_LOG2:0] level;
`ifdef DAC_UNDERRUN_CNT_EN
  logic [15:0]       underrun_cnt;
`endif

  dac_sample_feeder #(.RES(RES), .DEPTH_LOG2(DEPTH_LOG2), .DIV_W(DIV_W)) dut (
    .clk(clk), .reset(reset), .enable(enable), .rate_div(rate_div),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready), .dac_in(dac_in),
    .sample_tick(sample_tick), .underrun(underrun), .level(level)
`ifdef DAC_UNDERRUN_CNT_EN
    , .underrun_cnt(underrun_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: a sample queue plus the pacing rules.
  int        m_mode;     // 0 idle, 1 prime, 2 run
  int        m_cnt;
  bit        m_tick;
  bit        m_und;
  int        m_dac;
  int        m_ucnt;
  logic [RES:0] q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_mode = 0; m_cnt = 0; m_tick = 0; m_und = 0; m_dac = MID; m_ucnt = 0;
  endtask

  // One clock of the model, using the inputs present at the edge.
  task automatic model_step();
    int  n;
    int  next_mode;
    bit  tick_now, push, pop, und, new_tick;
    n = q.size();
    tick_now = m_tick;
    push = s_valid && (n < DEPTH);
    pop = 0; und = 0; new_tick = 0;
    next_mode = m_mode;
    if (m_mode == 0) begin
      if (enable) next_mode = 1;
    end else if (m_mode == 1) begin
      if (!enable) next_mode = 0;
      else if (n >= HALF) next_mode = 2;
    end else begin
      if (!enable) next_mode = 0;
      else if (tick_now) begin
        if (n == 0) begin und = 1; next_mode = 1; end
        else pop = 1;
      end
    end
    if (m_mode == 2) begin
      new_tick = enable && (m_cnt >= int'(rate_div)) && !und;
      m_cnt = (m_cnt >= int'(rate_div)) ? 0 : m_cnt + 1;
    end else begin
      m_cnt = 0;
    end
    if (pop) m_dac = int'(q.pop_front());
    if (next_mode == 0) m_dac = MID;
    if (push) q.push_back(s_data);
    m_und = und;
    if (und && m_ucnt != 16'hFFFF) m_ucnt++;
    m_mode = next_mode;
    m_tick = new_tick;
  endtask

  task automatic compare_all();
    check("dac_in",      32'(dac_in),      32'(m_dac));
    check("sample_tick", 32'(sample_tick), 32'(m_tick));
    check("underrun",    32'(underrun),    32'(m_und));
    check("level",       32'(level),       32'(q.size()));
    check("s_ready",     32'(s_ready),     32'(q.size() < DEPTH));
`ifdef DAC_UNDERRUN_CNT_EN
    check("underrun_cnt", 32'(underrun_cnt), 32'(m_ucnt));
`endif
  endtask

  task automatic step_cycle();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  initial begin
    int vprob;
    model_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_dac",   32'(dac_in), 32'(MID));
    check("reset_ready", 32'(s_ready), 32'd1);
    check("reset_level", 32'(level), 32'd0);
    reset = 1'b0;

    // Idle observation after reset.
    repeat (10) step_cycle();

    // Fill to full while disabled; extra valids must be refused.
    s_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      s_data = 8'($urandom);
      step_cycle();
    end
    s_valid = 1'b0;

    // Stream out without refill until underrun.
    enable = 1'b1;
    rate_div = 16'd3;
    repeat (100) step_cycle();

    // Randomized segments: rate, push density and enable vary per segment.
    for (int seg = 0; seg < 24; seg++) begin
      rate_div = 16'($urandom_range(0, 5));
      enable   = ($urandom_range(0, 9) != 0);
      case ($urandom_range(0, 3))
        0: vprob = 0;
        1: vprob = 30;
        2: vprob = 70;
        default: vprob = 100;
      endcase
      for (int c = 0; c < 40; c++) begin
        s_valid = ($urandom_range(0, 99) < vprob);
        s_data  = 8'($urandom);
        if ($urandom_range(0, 49) == 0) rate_div = 16'($urandom_range(0, 5));
        step_cycle();
      end
    end

    // Asynchronous reset while streaming: outputs clear without a clock edge.
    enable = 1'b1; rate_div = 16'd1; s_valid = 1'b1;
    for (int c = 0; c < 30; c++) begin
      s_data = 8'($urandom);
      step_cycle();
    end
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_dac",   32'(dac_in), 32'(MID));
    check("async_rst_level", 32'(level), 32'd0);
    check("async_rst_tick",  32'(sample_tick), 32'd0);
`ifdef DAC_UNDERRUN_CNT_EN
    check("async_rst_ucnt",  32'(underrun_cnt), 32'd0);
`endif
    model_reset();
    s_valid = 1'b0; enable = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    compare_all();

    // Short random tail after reset release.
    for (int c = 0; c < 200; c++) begin
      enable  = ($urandom_range(0, 19) != 0);
      s_valid = ($urandom_range(0, 1) == 1);
      s_data  = 8'($urandom);
      if ($urandom_range(0, 29) == 0) rate_div = 16'($urandom_range(0, 4));
      step_cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dac_sample_feeder.md
Name: dac_sample_feeder

Overview:
- Sample-rate pacing stage directly upstream of the first-order delta-sigma DAC.
- Accepts (RES+1)-bit unsigned samples from a producer over a valid/ready handshake and buffers them in a small FIFO.
- Presents one sample per programmable sample period on a registered dac_in bus that drives the DAC modulator input.
- Handles prefill, underrun and enable/disable so the modulator always sees a defined, glitch-free value.

Parameters:
- RES, 7, MSB index of sample; sample width is RES+1 bits, matching the DAC input.
- DEPTH_LOG2, 4, FIFO depth is 2^DEPTH_LOG2 entries.
- DIV_W, 16, width of the sample-period divider.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- enable  input  1  1 = stream samples to the DAC; 0 = idle
- rate_div  input  DIV_W  sample period minus one, in clk cycles
- s_data  input  RES+1  sample from producer, unsigned
- s_valid  input  1  s_data valid
- s_ready  output  1  FIFO can accept a sample
- dac_in  output  RES+1  registered sample to the DAC modulator
- sample_tick  output  1  one-cycle pulse when a sample-period boundary occurs
- underrun  output  1  one-cycle pulse: tick occurred with FIFO empty in RUN
- level  output  DEPTH_LOG2+1  current FIFO occupancy, 0..2^DEPTH_LOG2

Behaviour:
- Reset values (asynchronous):
  - FIFO pointers and level = 0; state = IDLE; divider = 0.
  - dac_in = midscale (1<<RES, 8'h80 at default).
  - sample_tick = 0; underrun = 0.
  - s_ready = 1.
- FIFO:
  - s_ready = !full, where full is registered (level == 2^DEPTH_LOG2).
  - Write when s_valid && s_ready. The write is visible in level and the head on the next cycle.
  - A pop in the same cycle as a push is allowed; level is then unchanged.
  - No write occurs while full, even if a pop happens in that cycle.
- Divider:
  - Active only in RUN. It counts 0..rate_div, and sample_tick pulses in the cycle the counter >= rate_div; the counter then returns to 0.
  - rate_div = 0 gives a tick every cycle.
  - If rate_div is reduced mid-count below the current count, the >= comparison forces an immediate tick and wrap.
  - Outside RUN the divider is held at 0.
- State machine:
  - IDLE: dac_in = midscale.
    - enable=1 -> PRIME.
    - The FIFO keeps accepting writes.
  - PRIME: divider held, dac_in holds its last value.
    - level >= 2^(DEPTH_LOG2-1) (8 at default) -> RUN.
    - enable=0 -> IDLE.
  - RUN: on sample_tick, one of two cases applies:
    - FIFO non-empty: pop the head and load dac_in with it in the same edge. dac_in changes the cycle after sample_tick is asserted.
    - FIFO empty: underrun pulses, dac_in holds its last value, and state -> PRIME. A push arriving in the same cycle does not prevent the underrun.
    - enable=0 -> IDLE; dac_in <= midscale on the next edge.
    - enable=0 takes priority over a tick in the same cycle: no pop occurs.
- Latency: the first sample appears at dac_in rate_div+2 cycles after PRIME->RUN.
- Reset mid-stream: all state is cleared immediately and the FIFO contents are discarded.
- All outputs are registered except s_ready, which is a direct decode of a register.

Optional Feature:
- Macro: DAC_UNDERRUN_CNT_EN.
- When defined:
  - Adds output underrun_cnt [15:0]: counts underrun pulses, saturating at 16'hFFFF.
  - Cleared only by reset.
- When undefined:
  - The port and counter are absent.
  - underrun pulse behaviour is identical.

Test Plan:
- Reset, then observe for 10 cycles -> dac_in=8'h80, s_ready=1, level=0, no sample_tick.
- Push 8 samples 8'h10..8'h17, enable=1, rate_div=3 -> RUN; sample_tick every 4 cycles; dac_in steps 10,11,...,17 one cycle after each tick; level decrements by 1 per tick.
- After the previous scenario drains -> next tick gives underrun=1, dac_in stays 8'h17, state PRIME. Push 8 more samples -> streaming resumes.
- Fill 16 samples with enable=0 -> s_ready=0 and level=16; a 17th s_valid is not accepted. Enable -> first pop, and s_ready returns to 1 the next cycle.
- Set rate_div=0 with FIFO full and continuous pushes -> tick every cycle; level stays constant with simultaneous push and pop; no underrun.
- Assert reset mid-stream while dac_in=8'h33 and level=5 -> dac_in=8'h80 and level=0 immediately. With DAC_UNDERRUN_CNT_EN defined, after 3 forced underruns, underrun_cnt=3 and reset clears it.
